// File: rtl/pwm_pkg.sv
// rtl/pwm_pkg.sv - shared constants, state type and conversion helpers for pwm_demod (PWM_DEMOD_AVG_EN adds the averaged conversion)
package pwm_pkg;

  localparam int PWM_FRAME = 32;
  localparam int PHASE_W   = 5;
  localparam int SAMPLE_W  = 24;
  localparam int HC_W      = 6;

  localparam logic [SAMPLE_W-1:0] MIDSCALE   = 24'h800000;
  localparam logic [SAMPLE_W-1:0] FULLSCALE  = 24'hFFFFFF;
  localparam logic [PHASE_W-1:0]  LAST_PHASE = PHASE_W'(PWM_FRAME - 1);

  typedef enum logic {
    SEARCH = 1'b0,
    RUN    = 1'b1
  } pwm_state_e;

  // High count of one frame (0..32) to a sample; a full frame of high saturates.
  function automatic logic [SAMPLE_W-1:0] hc_to_sample(input logic [HC_W-1:0] hc);
    if (hc[HC_W-1]) begin
      return FULLSCALE;
    end
    return {hc[HC_W-2:0], 19'b0};
  endfunction

`ifdef PWM_DEMOD_AVG_EN
  // Sum of two frame counts (0..64) to a sample; 64 saturates.
  function automatic logic [SAMPLE_W-1:0] sum_to_sample(input logic [HC_W:0] sum);
    if (sum[HC_W]) begin
      return FULLSCALE;
    end
    return {sum[HC_W-1:0], 18'b0};
  endfunction
`endif

endpackage

// File: rtl/pwm_sync.sv
// rtl/pwm_sync.sv - input synchronizer and rising-edge detector for the PWM stream
module pwm_sync #(
  parameter int SYNC_STAGES = 2
) (
  input  logic mck,
  input  logic rst,
  input  logic pwm_in,
  output logic pwm_s,
  output logic rise
);

  // SYNC_STAGES must be at least 2 so the first flop can settle before use.
  logic [SYNC_STAGES-1:0] sync_q;
  logic                   pwm_s_d;

  // Shift the asynchronous input through the chain and keep one delayed copy for the edge detector.
  always_ff @(posedge mck) begin
    if (rst) begin
      sync_q  <= '0;
      pwm_s_d <= 1'b0;
    end else begin
      sync_q  <= {sync_q[SYNC_STAGES-2:0], pwm_in};
      pwm_s_d <= sync_q[SYNC_STAGES-1];
    end
  end

  assign pwm_s = sync_q[SYNC_STAGES-1];
  assign rise  = pwm_s & ~pwm_s_d;

endmodule

// File: rtl/pwm_demod.sv
// rtl/pwm_demod.sv - PWM frame demodulator top: lock FSM, high counter and conversion (PWM_DEMOD_AVG_EN averages two frames)
module pwm_demod
  import pwm_pkg::*;
#(
  parameter int SYNC_STAGES = 2
) (
  input  logic                mck,
  input  logic                rst,
  input  logic                pwm_in,
  output logic [SAMPLE_W-1:0] sample,
  output logic                sample_valid,
  output logic                locked,
  output logic                sync_err,
  output logic [PHASE_W-1:0]  phase
);

  logic pwm_s;
  logic rise;

  pwm_sync #(
    .SYNC_STAGES(SYNC_STAGES)
  ) u_sync (
    .mck   (mck),
    .rst   (rst),
    .pwm_in(pwm_in),
    .pwm_s (pwm_s),
    .rise  (rise)
  );

  pwm_state_e          state;
  logic [HC_W-1:0]     hc;
  logic [PHASE_W-1:0]  tmo;
  logic                err_f;

  // Count for the frame including the current bit; at frame end this is the final count.
  logic [HC_W-1:0]     hc_final;
  logic                frame_end;
  logic                bad_rise;
  logic                frame_bad;
  logic [SAMPLE_W-1:0] frame_sample;

  assign hc_final  = hc + HC_W'(pwm_s);
  assign frame_end = (state == RUN) && (phase == LAST_PHASE);
  assign bad_rise  = rise && (phase != '0);
  // A misplaced rise on the frame-end cycle itself must also drop the frame.
  assign frame_bad = err_f | bad_rise;

`ifdef PWM_DEMOD_AVG_EN
  logic [HC_W-1:0] prev_hc;
  logic            avg_first;
  logic [HC_W:0]   avg_sum;

  // The first frame after lock pairs with itself, so it comes out unaveraged.
  assign avg_sum      = {1'b0, hc_final} + (avg_first ? {1'b0, hc_final} : {1'b0, prev_hc});
  assign frame_sample = sum_to_sample(avg_sum);

  // Track the previous frame count; timeout emissions seed it with the constant level.
  always_ff @(posedge mck) begin
    if (rst) begin
      prev_hc   <= 6'd16;
      avg_first <= 1'b0;
    end else if (state == SEARCH) begin
      if (rise) begin
        avg_first <= 1'b1;
      end else if (tmo == LAST_PHASE) begin
        prev_hc <= pwm_s ? 6'd32 : 6'd0;
      end
    end else if (frame_end && !frame_bad) begin
      prev_hc   <= hc_final;
      avg_first <= 1'b0;
    end
  end
`else
  assign frame_sample = hc_to_sample(hc_final);
`endif

  // Lock FSM: search for a rising edge (emitting constant levels on timeout), then count frames.
  always_ff @(posedge mck) begin
    if (rst) begin
      state        <= SEARCH;
      phase        <= '0;
      hc           <= '0;
      tmo          <= '0;
      err_f        <= 1'b0;
      sample       <= MIDSCALE;
      sample_valid <= 1'b0;
      locked       <= 1'b0;
      sync_err     <= 1'b0;
    end else begin
      sample_valid <= 1'b0;
      sync_err     <= 1'b0;
      case (state)
        SEARCH: begin
          phase <= '0;
          if (rise) begin
            // The rise cycle is phase 0 of the first frame and already holds one high bit.
            state  <= RUN;
            phase  <= PHASE_W'(1);
            hc     <= HC_W'(1);
            err_f  <= 1'b0;
            tmo    <= '0;
            locked <= 1'b1;
          end else if (tmo == LAST_PHASE) begin
            tmo          <= '0;
            sample       <= pwm_s ? FULLSCALE : '0;
            sample_valid <= 1'b1;
          end else begin
            tmo <= tmo + 1'b1;
          end
        end
        RUN: begin
          phase <= phase + 1'b1;
          tmo   <= '0;
          if (frame_end) begin
            // Clearing hc here lets the next phase-0 bit load it through the normal accumulate.
            hc    <= '0;
            err_f <= 1'b0;
            if (frame_bad) begin
              state    <= SEARCH;
              phase    <= '0;
              sync_err <= 1'b1;
              locked   <= 1'b0;
            end else begin
              sample       <= frame_sample;
              sample_valid <= 1'b1;
            end
          end else begin
            hc <= hc_final;
            if (bad_rise) begin
              err_f <= 1'b1;
            end
          end
        end
        default: begin
          state <= SEARCH;
        end
      endcase
    end
  end

endmodule
